fir_filter_mac: RTL and testbench

Parametrised successor to the fixed moving-average FIR. It filters NUM_LEADS EKG channels with a runtime-loadable KERNEL_SIZE-tap signed kernel and a runtime output shift. Rounding and saturation are applied on output. Area is bounded by one time-multiplexed MAC per lead, iterating over the taps. Sits between the ADC sample stream and downstream EKG processing; uses a ready/valid handshake instead of assuming one sample per cycle.

---
 rtl/fir_filter_mac.sv | 179 +++++++++++++++++
 tb/tb_fir_filter_mac.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// fir_filter_mac: multi-lead FIR, one time-multiplexed MAC per lead.
// Runtime kernel and shift; round-half-up and saturation on the output.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   signed_data_in          one signed sample per lead
//   data_valid_in/ready_out sample handshake (ready also gates coeff writes)
//   coeff_wr_en_in/addr/data  kernel tap write h[k]
//   shift_in                arithmetic right shift, captured with the sample
//   signed_data_out/sat_out filtered samples, per-lead clip flags
//   data_valid_out          one-cycle result strobe
module fir_filter_mac #(
  parameter int DATA_RESOLUTION  = 8,
  parameter int COEFF_RESOLUTION = 8,
  parameter int NUM_LEADS        = 1,
  parameter int KERNEL_SIZE      = 40,
  localparam int ACC_WIDTH = DATA_RESOLUTION + COEFF_RESOLUTION
                           + $clog2(KERNEL_SIZE),
  localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH),
  localparam int AW = $clog2(KERNEL_SIZE)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [NUM_LEADS*DATA_RESOLUTION-1:0] signed_data_in,
  input  logic                                 data_valid_in,
  output logic                                 ready_out,
  input  logic                                 coeff_wr_en_in,
  input  logic [AW-1:0]                        coeff_addr_in,
  input  logic [COEFF_RESOLUTION-1:0]          coeff_data_in,
  input  logic [SHIFT_WIDTH-1:0]               shift_in,
  output logic [NUM_LEADS*DATA_RESOLUTION-1:0] signed_data_out,
  output logic                                 data_valid_out,
  output logic [NUM_LEADS-1:0]                 sat_out
);

  localparam int DW = DATA_RESOLUTION;
  localparam int CW = COEFF_RESOLUTION;
  localparam int PW = DW + CW;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic [AW-1:0] LAST = AW'(KERNEL_SIZE - 1);
  localparam logic [AW:0] KLIM = (AW + 1)'(KERNEL_SIZE);
  localparam logic signed [RW-1:0] OMAX = RW'(2 ** (DW - 1) - 1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t state;
  logic ready_q;
  logic valid_q;
  logic drain_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tap;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [NUM_LEADS-1:0] sat_q;

  logic signed [CW-1:0] coeff [KERNEL_SIZE];
  logic signed [DW-1:0] hist [NUM_LEADS][KERNEL_SIZE];
  logic signed [PW-1:0] prod_q [NUM_LEADS];
  logic signed [ACC_WIDTH-1:0] acc [NUM_LEADS];
  logic signed [DW-1:0] dout_q [NUM_LEADS];

  logic signed [DW-1:0] lead_in [NUM_LEADS];
  logic signed [PW-1:0] mult [NUM_LEADS];
  logic signed [RW-1:0] bias;
  logic signed [RW-1:0] biased [NUM_LEADS];
  logic signed [RW-1:0] rnd [NUM_LEADS];
  logic signed [DW-1:0] clip [NUM_LEADS];
  logic [NUM_LEADS-1:0] clip_sat;

  logic accept;
  logic coeff_wr;

  assign accept = data_valid_in && ready_q;
  assign coeff_wr = coeff_wr_en_in && ready_q
                  && ({1'b0, coeff_addr_in} < KLIM);
  assign bias = (shift_q != '0)
              ? (RW'(1) << (shift_q - 1'b1)) : '0;

  // One extra bit over the accumulator absorbs the rounding bias.
  always_comb begin
    for (int l = 0; l < NUM_LEADS; l++) begin
      lead_in[l] = signed_data_in[l*DW +: DW];
      mult[l] = hist[l][rd_ptr] * coeff[tap];
      biased[l] = RW'(acc[l]) + bias;
      rnd[l] = biased[l] >>> shift_q;
      clip[l] = rnd[l][DW-1:0];
      clip_sat[l] = 1'b0;
      if (rnd[l] > OMAX) begin
        clip[l] = OMAX[DW-1:0];
        clip_sat[l] = 1'b1;
      end else if (rnd[l] < OMIN) begin
        clip[l] = OMIN[DW-1:0];
        clip_sat[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      drain_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tap     <= '0;
      shift_q <= '0;
      sat_q   <= '0;
      for (int k = 0; k < KERNEL_SIZE; k++) coeff[k] <= CW'(1);
      for (int l = 0; l < NUM_LEADS; l++) begin
        prod_q[l] <= '0;
        acc[l]    <= '0;
        dout_q[l] <= '0;
        for (int k = 0; k < KERNEL_SIZE; k++) hist[l][k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (coeff_wr) coeff[coeff_addr_in] <= coeff_data_in;
      unique case (state)
        IDLE: begin
          if (accept) begin
            for (int l = 0; l < NUM_LEADS; l++) begin
              hist[l][wr_ptr] <= lead_in[l];
              prod_q[l] <= '0;
              acc[l] <= '0;
            end
            rd_ptr  <= wr_ptr;
            wr_ptr  <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            tap     <= '0;
            shift_q <= shift_in;
            ready_q <= 1'b0;
            state   <= MAC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        // Product is registered; the sum lags it by one cycle.
        MAC: begin
          for (int l = 0; l < NUM_LEADS; l++) begin
            prod_q[l] <= mult[l];
            acc[l] <= acc[l] + ACC_WIDTH'(prod_q[l]);
          end
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
          tap <= tap + 1'b1;
          if (tap == LAST) begin
            drain_q <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          for (int l = 0; l < NUM_LEADS; l++) begin
            prod_q[l] <= '0;
            acc[l] <= acc[l] + ACC_WIDTH'(prod_q[l]);
          end
          drain_q <= 1'b1;
          if (drain_q) begin
            for (int l = 0; l < NUM_LEADS; l++) dout_q[l] <= clip[l];
            sat_q <= clip_sat;
            valid_q <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          ready_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = ready_q;
  assign data_valid_out = valid_q;
  assign sat_out = sat_q;

  for (genvar l = 0; l < NUM_LEADS; l++) begin : g_out
    assign signed_data_out[l*DW +: DW] = dout_q[l];
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// tb_fir_filter_mac: scoreboard bench, K=4 two-lead and K=40 one-lead
// instances; directed vectors with hand-computed expectations.
module tb_fir_filter_mac;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int K4 = 4;
  localparam int L4 = 2;
  localparam int A4 = $clog2(K4);
  localparam int S4 = $clog2(DW + CW + A4);
  localparam int K40 = 40;
  localparam int A40 = $clog2(K40);
  localparam int S40 = $clog2(DW + CW + A40);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  logic rst4, dv4, rdy4, cwe4, dvo4;
  logic [L4*DW-1:0] din4, dout4;
  logic [A4-1:0] ca4;
  logic [CW-1:0] cd4;
  logic [S4-1:0] sh4;
  logic [L4-1:0] sat4;

  logic rst40, dv40, rdy40, cwe40, dvo40;
  logic [DW-1:0] din40, dout40;
  logic [A40-1:0] ca40;
  logic [CW-1:0] cd40;
  logic [S40-1:0] sh40;
  logic [0:0] sat40;

  fir_filter_mac #(
    .DATA_RESOLUTION(DW), .COEFF_RESOLUTION(CW),
    .NUM_LEADS(L4), .KERNEL_SIZE(K4)
  ) u4 (
    .clk_in(clk), .rst_n_in(rst4),
    .signed_data_in(din4), .data_valid_in(dv4), .ready_out(rdy4),
    .coeff_wr_en_in(cwe4), .coeff_addr_in(ca4), .coeff_data_in(cd4),
    .shift_in(sh4), .signed_data_out(dout4),
    .data_valid_out(dvo4), .sat_out(sat4)
  );

  fir_filter_mac #(
    .DATA_RESOLUTION(DW), .COEFF_RESOLUTION(CW),
    .NUM_LEADS(1), .KERNEL_SIZE(K40)
  ) u40 (
    .clk_in(clk), .rst_n_in(rst40),
    .signed_data_in(din40), .data_valid_in(dv40), .ready_out(rdy40),
    .coeff_wr_en_in(cwe40), .coeff_addr_in(ca40), .coeff_data_in(cd40),
    .shift_in(sh40), .signed_data_out(dout40),
    .data_valid_out(dvo40), .sat_out(sat40)
  );

  typedef struct {
    int d0;
    int d1;
    int s;
  } exp_t;

  exp_t q4[$];
  exp_t q40[$];
  int acc4[$];
  int acc40[$];
  int nacc4 = 0;
  int nacc40 = 0;
  int nout4 = 0;
  int nout40 = 0;
  int last4 = -1;
  bit stream4 = 1'b0;
  exp_t e4, e40;
  int a4, a40;

  // Accept detection: an accept lands on the next rising edge.
  always @(negedge clk) begin
    if (rst4 && dv4 && rdy4) begin
      if (stream4 && last4 >= 0)
        chk("u4_accept_period", cyc + 1 - last4, K4 + 4);
      last4 = cyc + 1;
      acc4.push_back(cyc + 1);
      nacc4++;
    end
    if (rst40 && dv40 && rdy40) begin
      acc40.push_back(cyc + 1);
      nacc40++;
    end
  end

  // Output monitors: pop expected result and accept edge per strobe.
  always @(negedge clk) begin
    if (rst4 && dvo4) begin
      if (q4.size() == 0 || acc4.size() == 0) begin
        chk("u4_unexpected_valid", dvo4, 0);
      end else begin
        e4 = q4.pop_front();
        a4 = acc4.pop_front();
        chk($sformatf("u4_lead0[%0d]", nout4), $signed(dout4[DW-1:0]), e4.d0);
        chk($sformatf("u4_lead1[%0d]", nout4), $signed(dout4[2*DW-1:DW]), e4.d1);
        chk($sformatf("u4_sat[%0d]", nout4), sat4, e4.s);
        chk($sformatf("u4_latency[%0d]", nout4), cyc - a4 + 1, K4 + 3);
        nout4++;
      end
    end
    if (rst40 && dvo40) begin
      if (q40.size() == 0 || acc40.size() == 0) begin
        chk("u40_unexpected_valid", dvo40, 0);
      end else begin
        e40 = q40.pop_front();
        a40 = acc40.pop_front();
        chk($sformatf("u40_data[%0d]", nout40), $signed(dout40), e40.d0);
        chk($sformatf("u40_sat[%0d]", nout40), sat40, e40.s);
        chk($sformatf("u40_latency[%0d]", nout40), cyc - a40 + 1, K40 + 3);
        nout40++;
      end
    end
  end

  task automatic wait_rdy4();
    int n = 0;
    while (!rdy4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u4_ready_wait", rdy4, 1);
  endtask

  task automatic send4(input int d0, input int d1, input int sh,
                       input int x0, input int x1, input int xs);
    exp_t t;
    wait_rdy4();
    din4 = {DW'(d1), DW'(d0)};
    sh4 = S4'(sh);
    dv4 = 1'b1;
    t.d0 = x0;
    t.d1 = x1;
    t.s = xs;
    q4.push_back(t);
    @(posedge clk); #1;
    dv4 = 1'b0;
    sh4 = S4'(sh + 3);
    din4 = '1;
  endtask

  task automatic wr4(input int a, input int d);
    wait_rdy4();
    cwe4 = 1'b1;
    ca4 = A4'(a);
    cd4 = CW'(d);
    @(posedge clk); #1;
    cwe4 = 1'b0;
  endtask

  task automatic idle4();
    int n = 0;
    while (q4.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u4_drain", q4.size(), 0);
  endtask

  task automatic reset4();
    rst4 = 1'b0;
    #1;
    chk("u4_rst_ready", rdy4, 0);
    chk("u4_rst_valid", dvo4, 0);
    chk("u4_rst_data", dout4, 0);
    chk("u4_rst_sat", sat4, 0);
    acc4.delete();
    last4 = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk); #1;
    chk("u4_ready_release", rdy4, 1);
  endtask

  task automatic run4();
    exp_t t;
    int base;
    int n;
    reset4();
    // Kernel [1,2,3,4] impulse response.
    wr4(1, 2); wr4(2, 3); wr4(3, 4);
    send4( 1, -2, 0, 1, -2, 0);
    send4( 0,  1, 0, 2, -3, 0);
    send4( 0,  0, 0, 3, -4, 0);
    send4( 0,  0, 0, 4, -5, 0);
    send4( 0,  0, 0, 0,  4, 0);
    send4( 0,  0, 0, 0,  0, 0);
    idle4();
    // Saturation with all taps 127.
    reset4();
    for (int k = 0; k < K4; k++) wr4(k, 127);
    send4(  0,  0, 0,    0,    0, 0);
    send4(127, -1, 0,  127, -127, 1);
    idle4();
    reset4();
    for (int k = 0; k < K4; k++) wr4(k, 127);
    send4(-128, 1, 0, -128, 127, 1);
    idle4();
    // Rounding: single tap, shift 1 and 2.
    reset4();
    wr4(1, 0); wr4(2, 0); wr4(3, 0);
    send4(-3,  1, 1, -1, 1, 0);
    send4( 3, -1, 1,  2, 0, 0);
    send4(-4,  2, 1, -2, 1, 0);
    send4(-2,  6, 2,  0, 2, 0);
    idle4();
    // Reset in the middle of MAC.
    reset4();
    wr4(0, 5);
    send4(7, 1, 0, 35, 5, 0);
    idle4();
    wait_rdy4();
    din4 = {DW'(2), DW'(9)};
    sh4 = '0;
    dv4 = 1'b1;
    @(posedge clk); #1;
    dv4 = 1'b0;
    @(posedge clk); #3;
    reset4();
    send4(3, 4, 0, 3, 4, 0);
    idle4();
    // Continuous valid; busy coefficient write must be ignored.
    reset4();
    for (int i = 0; i < 6; i++) begin
      t.d0 = 10 * ((i < K4) ? i + 1 : K4);
      t.d1 = -5 * ((i < K4) ? i + 1 : K4);
      t.s = 0;
      q4.push_back(t);
    end
    base = nacc4;
    sh4 = '0;
    din4 = {DW'(-5), DW'(10)};
    stream4 = 1'b1;
    dv4 = 1'b1;
    n = 0;
    while (nacc4 - base < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u4_busy_ready", rdy4, 0);
    cwe4 = 1'b1;
    ca4 = '0;
    cd4 = CW'(50);
    @(posedge clk); #1;
    cwe4 = 1'b0;
    n = 0;
    while (nacc4 - base < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    dv4 = 1'b0;
    chk("u4_stream_accepts", nacc4 - base, 6);
    idle4();
    stream4 = 1'b0;
  endtask

  task automatic run40();
    exp_t t;
    int n = 0;
    rst40 = 1'b0;
    #1;
    chk("u40_rst_ready", rdy40, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst40 = 1'b1;
    @(posedge clk); #1;
    chk("u40_ready_release", rdy40, 1);
    // Default all-ones kernel, shift 5, constant 100.
    for (int i = 0; i < 42; i++) begin
      t.d0 = (100 * ((i < K40) ? i + 1 : K40) + 16) >>> 5;
      t.d1 = 0;
      t.s = 0;
      q40.push_back(t);
    end
    sh40 = S40'(5);
    din40 = DW'(100);
    dv40 = 1'b1;
    while (nacc40 < 42 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    dv40 = 1'b0;
    chk("u40_accepts", nacc40, 42);
    n = 0;
    while (q40.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u40_drain", q40.size(), 0);
  endtask

  initial begin
    rst4 = 1'b1;
    rst40 = 1'b1;
    dv4 = 1'b0;
    dv40 = 1'b0;
    din4 = '0;
    din40 = '0;
    cwe4 = 1'b0;
    ca4 = '0;
    cd4 = '0;
    sh4 = '0;
    cwe40 = 1'b0;
    ca40 = '0;
    cd40 = '0;
    sh40 = '0;
    #1;
    fork
      run4();
      run40();
    join
    chk("u4_outputs", nout4, 21);
    chk("u40_outputs", nout40, 42);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
